// File: rtl/nx_roreg_indirect_access_mt_pkg.sv
// Shared types and constants for the multi-table read-only indirect access block.
//   op_e        : command opcodes accepted in the command register
//   stat_code_e : status codes reported in the status register
//   state_e     : access FSM states
//   CAPABILITIES, ROREG_TYPE : constant identification fields
//   datawords() : number of 32-bit words in one entry
package nx_roreg_ia_pkg;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_READ      = 4'd1,
    OP_READ_NEXT = 4'd2
  } op_e;

  typedef enum logic [2:0] {
    ST_RDY         = 3'd0,
    ST_BUSY        = 3'd1,
    ST_ERROR       = 3'd2,
    ST_UNSUPPORTED = 3'd3,
    ST_TABLE_ERR   = 3'd4
  } stat_code_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE
  } state_e;

  // Bits 0..2 advertise NOP, READ and READ_NEXT.
  localparam logic [15:0] CAPABILITIES = 16'h0007;
  localparam logic [3:0]  ROREG_TYPE   = 4'h0;

  function automatic logic [4:0] datawords(input int n_bits);
    return 5'((n_bits + 31) / 32);
  endfunction

endpackage

// File: rtl/nx_roreg_indirect_access_mt_if.sv
// CSR command bus of the indirect access block.
//   addr          : CSR address
//   wr_stb        : CSR write strobe
//   cmnd_op       : decoded command opcode
//   cmnd_addr     : entry index
//   cmnd_table_id : table select
// master drives the bus (CSR decoder / bench), slave is the access block.
interface nx_roreg_indirect_access_mt_if #(
  parameter int N_REG_ADDR_BITS = 11,
  parameter int AW              = 5,
  parameter int TW              = 1
);
  logic [N_REG_ADDR_BITS-1:0] addr;
  logic                       wr_stb;
  logic [3:0]                 cmnd_op;
  logic [AW-1:0]              cmnd_addr;
  logic [TW-1:0]              cmnd_table_id;

  modport master (
    output addr, wr_stb, cmnd_op, cmnd_addr, cmnd_table_id
  );

  modport slave (
    input addr, wr_stb, cmnd_op, cmnd_addr, cmnd_table_id
  );
endinterface

// File: rtl/nx_roreg_indirect_access_mt_mux.sv
// Registered entry selector over N_TABLES x N_ENTRIES flattened entries.
//   clk, rst_n : clock, async active-low reset (clears dat)
//   en         : load the selected entry into dat this cycle
//   table_id   : table index, entry : entry index (must be in range when en=1)
//   mem_a      : flattened tables, entry (t,e) at bit (t*N_ENTRIES+e)*N_DATA_BITS
//   dat        : last loaded entry, updated as one word
module nx_roreg_ia_mux #(
  parameter  int N_DATA_BITS = 64,
  parameter  int N_ENTRIES   = 32,
  parameter  int N_TABLES    = 2,
  localparam int AW          = $clog2(N_ENTRIES),
  localparam int TW          = (N_TABLES > 1) ? $clog2(N_TABLES) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     en,
  input  logic [TW-1:0]                            table_id,
  input  logic [AW-1:0]                            entry,
  input  logic [N_TABLES*N_ENTRIES*N_DATA_BITS-1:0] mem_a,
  output logic [N_DATA_BITS-1:0]                   dat
);

  int unsigned idx;

  always_comb begin
    idx = 32'(table_id) * 32'(N_ENTRIES) + 32'(entry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat <= '0;
    end else if (en) begin
      dat <= mem_a[idx*N_DATA_BITS +: N_DATA_BITS];
    end
  end

endmodule

// File: rtl/nx_roreg_indirect_access_mt.sv
// Multi-table read-only indirect access block.
// A write to the command register selects a table/entry; the FSM waits for
// grant, snapshots the entry into rd_dat and reports completion in stat_code.
//   clk, rst_n      : clock, async active-low reset
//   csr             : CSR command bus (slave modport)
//   grant           : array may be read this cycle
//   mem_a           : flattened read-only tables
//   stat_code       : RDY/BUSY/ERROR/UNSUPPORTED/TABLE_ERR
//   stat_datawords  : 32-bit words per entry (constant)
//   stat_addr       : entry of the last or current command
//   stat_table_id   : table of the last or current command
//   capability_lst  : supported-op bitmap, capability_type : ROREG type code
//   rd_dat          : snapshot of the last successful read
//   busy            : FSM not idle
module nx_roreg_indirect_access_mt
  import nx_roreg_ia_pkg::*;
#(
  parameter  int                         N_REG_ADDR_BITS = 11,
  parameter  logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS    = 'h528,
  parameter  logic [N_REG_ADDR_BITS-1:0] STAT_ADDRESS    = 'h51c,
  parameter  int                         N_DATA_BITS     = 64,
  parameter  int                         N_ENTRIES       = 32,
  parameter  int                         N_TABLES        = 2,
  localparam int                         AW              = $clog2(N_ENTRIES),
  localparam int                         TW              = (N_TABLES > 1) ? $clog2(N_TABLES) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  nx_roreg_indirect_access_mt_if.slave              csr,
  input  logic                                      grant,
  input  logic [N_TABLES*N_ENTRIES*N_DATA_BITS-1:0] mem_a,
  output logic [2:0]                                stat_code,
  output logic [4:0]                                stat_datawords,
  output logic [AW-1:0]                             stat_addr,
  output logic [TW-1:0]                             stat_table_id,
  output logic [15:0]                               capability_lst,
  output logic [3:0]                                capability_type,
  output logic [N_DATA_BITS-1:0]                    rd_dat,
  output logic                                      busy
);

  state_e        state;
  stat_code_e    code_q;
  logic          cmnd_hit;
  logic [AW-1:0] tgt_entry;
  logic [TW-1:0] tgt_table;
  logic          table_ok;
  logic          entry_ok;

  assign stat_datawords  = datawords(N_DATA_BITS);
  assign capability_lst  = CAPABILITIES;
  assign capability_type = ROREG_TYPE;
  assign stat_code       = code_q;

  // The status register is read-only: even if it were mapped onto the command
  // address, a write there must never launch a command.
  assign cmnd_hit = csr.wr_stb && (csr.addr == CMND_ADDRESS) && (CMND_ADDRESS != STAT_ADDRESS);

  // READ_NEXT steps from the last target and wraps inside the same table.
  always_comb begin
    tgt_table = csr.cmnd_table_id;
    tgt_entry = csr.cmnd_addr;
    if (csr.cmnd_op == OP_READ_NEXT) begin
      tgt_table = stat_table_id;
      tgt_entry = (stat_addr == AW'(N_ENTRIES - 1)) ? '0 : stat_addr + AW'(1);
    end
    table_ok = 32'(tgt_table) < 32'(N_TABLES);
    entry_ok = 32'(tgt_entry) < 32'(N_ENTRIES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      code_q        <= ST_RDY;
      stat_addr     <= '0;
      stat_table_id <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmnd_hit) begin
            case (csr.cmnd_op)
              OP_NOP: code_q <= ST_RDY;
              OP_READ, OP_READ_NEXT: begin
                stat_addr     <= tgt_entry;
                stat_table_id <= tgt_table;
                if (!table_ok) begin
                  code_q <= ST_TABLE_ERR;
                end else if (!entry_ok) begin
                  code_q <= ST_ERROR;
                end else begin
                  code_q <= ST_BUSY;
                  busy   <= 1'b1;
                  state  <= S_WAIT;
                end
              end
              default: code_q <= ST_UNSUPPORTED;
            endcase
          end
        end
        S_WAIT: begin
          if (grant) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          code_q <= ST_RDY;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The target is held in stat_table_id/stat_addr while in WAIT/CAPTURE, so the
  // selector loads rd_dat on the same edge that leaves CAPTURE.
  nx_roreg_ia_mux #(
    .N_DATA_BITS (N_DATA_BITS),
    .N_ENTRIES   (N_ENTRIES),
    .N_TABLES    (N_TABLES)
  ) u_mux (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state == S_CAPTURE),
    .table_id (stat_table_id),
    .entry    (stat_addr),
    .mem_a    (mem_a),
    .dat      (rd_dat)
  );

endmodule

// File: tb/tb_nx_roreg_indirect_access_mt.sv
module tb_nx_roreg_indirect_access_mt;
  localparam int NT = 3;
  localparam int NE = 32;
  localparam int DB = 64;
  localparam int AW = 5;
  localparam int TW = 2;
  localparam int RA = 11;
  localparam logic [RA-1:0] CMND = 11'h528;
  localparam logic [RA-1:0] STAT = 11'h51c;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                grant = 1'b0;
  logic [NT*NE*DB-1:0] mem_a;
  logic [2:0]          stat_code;
  logic [4:0]          stat_datawords;
  logic [AW-1:0]       stat_addr;
  logic [TW-1:0]       stat_table_id;
  logic [15:0]         capability_lst;
  logic [3:0]          capability_type;
  logic [DB-1:0]       rd_dat;
  logic                busy;

  nx_roreg_indirect_access_mt_if #(.N_REG_ADDR_BITS(RA), .AW(AW), .TW(TW)) csr ();

  nx_roreg_indirect_access_mt #(
    .N_REG_ADDR_BITS (RA),
    .CMND_ADDRESS    (CMND),
    .STAT_ADDRESS    (STAT),
    .N_DATA_BITS     (DB),
    .N_ENTRIES       (NE),
    .N_TABLES        (NT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr             (csr),
    .grant           (grant),
    .mem_a           (mem_a),
    .stat_code       (stat_code),
    .stat_datawords  (stat_datawords),
    .stat_addr       (stat_addr),
    .stat_table_id   (stat_table_id),
    .capability_lst  (capability_lst),
    .capability_type (capability_type),
    .rd_dat          (rd_dat),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Reference model: table contents plus the architectural status fields.
  logic [DB-1:0] mem [NT][NE];
  int            m_code, m_addr, m_tab, m_busy;
  logic [DB-1:0] m_rd;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".stat_code"}, 64'(stat_code), 64'(m_code));
    chk({tag, ".stat_addr"}, 64'(stat_addr), 64'(m_addr));
    chk({tag, ".stat_table_id"}, 64'(stat_table_id), 64'(m_tab));
    chk({tag, ".rd_dat"}, rd_dat, m_rd);
    chk({tag, ".busy"}, 64'(busy), 64'(m_busy));
  endtask

  task automatic model_reset();
    m_code = 0; m_addr = 0; m_tab = 0; m_busy = 0; m_rd = '0;
  endtask

  task automatic pack();
    for (int t = 0; t < NT; t++)
      for (int e = 0; e < NE; e++)
        mem_a[(t*NE+e)*DB +: DB] = mem[t][e];
  endtask

  // Present one CSR write for one clock; returns one time unit after the edge.
  task automatic send(input logic [3:0] op, input logic [TW-1:0] tab, input logic [AW-1:0] ent,
                      input logic [RA-1:0] adr);
    csr.addr = adr; csr.cmnd_op = op; csr.cmnd_table_id = tab; csr.cmnd_addr = ent;
    csr.wr_stb = 1'b1;
    @(posedge clk); #1;
    csr.wr_stb = 1'b0;
  endtask

  // Issue a command from idle and follow it to completion against the model.
  task automatic exec(input logic [3:0] op, input int tab, input int ent, input bit rnd);
    int tt, ee, n;
    bit pend, gs;
    pend = 1'b0;
    if (op == 4'd1) begin tt = tab; ee = ent; end
    else begin tt = m_tab; ee = (m_addr + 1) % NE; end
    case (op)
      4'd0: m_code = 0;
      4'd1, 4'd2: begin
        m_addr = ee; m_tab = tt;
        if (tt >= NT) m_code = 4;
        else if (ee >= NE) m_code = 2;
        else begin m_code = 1; pend = 1'b1; end
      end
      default: m_code = 3;
    endcase
    m_busy = int'(pend);
    send(op, TW'(tab), AW'(ent), CMND);
    check_all("accept");
    if (pend) begin
      n = 0;
      do begin
        grant = rnd ? ((n > 12) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
        gs = grant;
        @(posedge clk); #1;
        n++;
        if (!gs) check_all("wait");
      end while (!gs);
      check_all("capture");
      @(posedge clk); #1;
      m_rd = mem[tt][ee]; m_code = 0; m_busy = 0;
      check_all("done");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    csr.addr = '0; csr.wr_stb = 1'b0; csr.cmnd_op = '0; csr.cmnd_addr = '0; csr.cmnd_table_id = '0;
    for (int t = 0; t < NT; t++)
      for (int e = 0; e < NE; e++)
        mem[t][e] = {$urandom, $urandom};
    mem[1][5] = 64'hDEAD_BEEF_0123_4567;
    pack();
    model_reset();

    // Reset values and constants
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_all("reset");
    chk("reset.stat_datawords", 64'(stat_datawords), 64'd2);
    chk("reset.capability_lst", 64'(capability_lst), 64'h0007);
    chk("reset.capability_type", 64'(capability_type), 64'h0);

    // Directed read with grant held high: T+1 busy, T+3 done
    exec(4'd1, 1, 5, 1'b0);
    chk("t2.rd_dat", rd_dat, 64'hDEAD_BEEF_0123_4567);

    // Last entry, then READ_NEXT wraps to entry 0 of the same table
    exec(4'd1, 0, 31, 1'b0);
    exec(4'd2, 3, 17, 1'b0);
    chk("t3.wrap_addr", 64'(stat_addr), 64'd0);

    // Grant withheld for 10 cycles; a command written meanwhile is ignored
    grant = 1'b0;
    m_addr = 7; m_tab = 0; m_code = 1; m_busy = 1;
    send(4'd1, 2'd0, 5'd7, CMND);
    check_all("t4.accept");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        csr.addr = CMND; csr.cmnd_op = 4'd1; csr.cmnd_table_id = 2'd2; csr.cmnd_addr = 5'd9;
        csr.wr_stb = 1'b1;
      end
      @(posedge clk); #1;
      csr.wr_stb = 1'b0;
      check_all("t4.wait");
    end
    grant = 1'b1;
    @(posedge clk); #1;
    check_all("t4.capture");
    @(posedge clk); #1;
    m_rd = mem[0][7]; m_code = 0; m_busy = 0;
    check_all("t4.done");
    @(posedge clk); #1;
    check_all("t4.idle");

    // Table out of range, unsupported op, status write, NOP, READ_NEXT from bad table
    exec(4'd1, 3, 4, 1'b0);
    exec(4'h9, 1, 1, 1'b0);
    send(4'd1, 2'd2, 5'd9, STAT);
    check_all("t5.stat_write");
    @(posedge clk); #1;
    check_all("t5.stat_write_idle");
    exec(4'd0, 2, 2, 1'b0);
    exec(4'd2, 0, 0, 1'b0);
    exec(4'h3, 0, 0, 1'b0);
    exec(4'hF, 0, 0, 1'b0);

    // Asynchronous reset while waiting for grant
    grant = 1'b0;
    exec(4'd1, 2, 20, 1'b0);
    grant = 1'b0;
    m_addr = 21; m_tab = 2; m_code = 1; m_busy = 1;
    send(4'd1, 2'd2, 5'd21, CMND);
    check_all("t6.accept");
    @(posedge clk); #1;
    check_all("t6.wait");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.async_reset");
    chk("t6.stat_datawords", 64'(stat_datawords), 64'd2);
    chk("t6.capability_lst", 64'(capability_lst), 64'h0007);
    grant = 1'b1;
    @(posedge clk); #1;
    check_all("t6.reset_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("t6.after_release");
    exec(4'd1, 2, 21, 1'b0);

    // Randomized command stream with random grant delays
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 5);
      case (r)
        0:       exec(4'd0, $urandom_range(0, 3), $urandom_range(0, 31), 1'b1);
        1, 2:    exec(4'd1, $urandom_range(0, 3), $urandom_range(0, 31), 1'b1);
        3, 4:    exec(4'd2, $urandom_range(0, 3), $urandom_range(0, 31), 1'b1);
        default: exec(4'($urandom_range(3, 15)), $urandom_range(0, 3), $urandom_range(0, 31), 1'b1);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
